soc_system_clk_div: RTL and testbench
=====================================

# soc_system_clk_div

Parametrised, runtime-reprogrammable clock-divider bank that derives NUM_CLK divided clocks and matching clock-enable strobes from a single reference clock. It is the next generation of the fixed five-output SoC clock generator: per-channel divide ratio and duty cycle are programmable, updates are applied glitch-free at period boundaries, all channels can be realigned together, and a lock indicator reports settled outputs. It sits beside the PLL in the SoC clocking subsystem and feeds low-rate peripheral clock enables.

## Interface
- NUM_CLK, 5, number of output channels (1..16)
- CNT_W, 16, counter/config width
- DEF_DIV, 10, reset divide ratio for every channel (2..2^CNT_W-1)
- DEF_HIGH, 5, reset high-time for every channel (1..DEF_DIV-1)
- LOCK_CYCLES, 16, stable refclk cycles required before `locked` rises (1..2^16-1)
- Derived: CH_W = max(1, $clog2(NUM_CLK))

- refclk  in  1  sole clock; all logic rising-edge
- rst_n  in  1  synchronous, active-low reset
- cfg_valid  in  1  configuration write request
- cfg_ready  out  1  write accepted this cycle when cfg_valid & cfg_ready
- cfg_chan  in  CH_W  target channel
- cfg_div  in  CNT_W  period in refclk cycles
- cfg_high  in  CNT_W  high cycles per period
- cfg_err  out  1  one-cycle pulse: write rejected
- sync  in  1  realign all channels
- outclk  out  NUM_CLK  divided clocks (registered)
- outclk_en  out  NUM_CLK  one-cycle strobe at start of each period (registered)
- locked  out  1  outputs stable

## Operation
- Per channel: active div/high registers, counter cnt 0..div-1, pending div/high + pend flag.
- outclk[i]=1 while cnt[i] < high[i]; outclk_en[i]=1 only when cnt[i]==0.
- cfg_ready = !pend[cfg_chan]; cfg_chan >= NUM_CLK → ready=1, write rejected.
- Accepted write checked: legal iff chan < NUM_CLK, div >= 2, 1 <= high <= div-1. Illegal: cfg_err pulses next cycle, no state change. Legal: stored in pending, pend set.
- Pending applied when cnt==div-1 (wrap): next cycle uses new div/high from count 0; pend clears; no runt pulse ever emitted.
- sync: all counters restart at 0 the next cycle; any pending updates applied at that point; sync wins over write acceptance in the same cycle (write still accepted into pending, applied at next wrap).
- locked: stability counter cleared by reset, sync, or any pending application; increments each cycle, saturates; locked=1 when counter >= LOCK_CYCLES.
- Legal write with illegal out-of-range chan: cfg_err only.

## Timing
- Reset (rst_n=0 at a rising edge): outclk=0, outclk_en=0, cfg_err=0, locked=0, pend=0, div=DEF_DIV, high=DEF_HIGH.
- First cycle after rst_n high: every channel at count 0 (outclk=1, outclk_en=1).
- Reset mid-operation discards pending writes; same sequence as power-up.
- Outputs registered; no combinational path from inputs to outclk/outclk_en/locked/cfg_err. cfg_ready is combinational from cfg_chan and pend.
- sync at cycle t → all channels count 0 at t+1; locked falls at t+1.
- locked rises LOCK_CYCLES cycles after the last clearing event.
- Write accepted at t with channel wrapping at t+1 → applied at t+2 period start at the earliest.

## Configuration
- CLK_DIV_PHASE_EN defined: adds input cfg_phase (CNT_W); legal 0..div-1 (else cfg_err); stored with div/high; on reset (DEF phase 0) and on sync each channel restarts at count=phase instead of 0, giving fixed inter-channel phase offsets; wrap-time updates still restart at 0.
- Not defined: cfg_phase port absent; all restarts at count 0.

## Test plan
- Reset release, defaults: each outclk 5 high/5 low, outclk_en every 10 cycles, all aligned; locked rises 16 cycles after release.
- Write ch2 div=4 high=1 mid-period: old period completes, then 1 high/3 low; locked drops at application, returns after 16 cycles.
- Illegal writes (div=1; high=0; high=div; chan=7 with NUM_CLK=5): cfg_err pulses, outputs unchanged.
- Second write to ch2 while pending: cfg_ready=0 until wrap, then accepted; writes to other channels accepted meanwhile.
- sync asserted with ch0 at count 6: next cycle all channels count 0, pending applied, locked=0.
- With CLK_DIV_PHASE_EN: ch1 div=10 phase=3, then sync: ch1 outclk_en occurs 7 cycles after ch0's; rst_n pulse mid-period restores defaults.

Source files
------------

// File: rtl/soc_system_clk_div_if.sv
// soc_system_clk_div configuration port bundle.
// cfg_phase exists only when CLK_DIV_PHASE_EN is defined.
interface soc_system_clk_div_if #(
  parameter int CH_W  = 3,
  parameter int CNT_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_chan;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_err;
`ifdef CLK_DIV_PHASE_EN
  logic [CNT_W-1:0] cfg_phase;

  modport master (
    output cfg_valid, cfg_chan, cfg_div,
    output cfg_high, cfg_phase,
    input  cfg_ready, cfg_err
  );
  modport slave (
    input  cfg_valid, cfg_chan, cfg_div,
    input  cfg_high, cfg_phase,
    output cfg_ready, cfg_err
  );
`else
  modport master (
    output cfg_valid, cfg_chan, cfg_div,
    output cfg_high,
    input  cfg_ready, cfg_err
  );
  modport slave (
    input  cfg_valid, cfg_chan, cfg_div,
    input  cfg_high,
    output cfg_ready, cfg_err
  );
`endif
endinterface

// File: rtl/soc_system_clk_div.sv
// Programmable clock-divider bank with glitch-free updates and lock flag.
// Define CLK_DIV_PHASE_EN for per-channel restart phase (cfg_phase).
module soc_system_clk_div #(
  parameter int NUM_CLK     = 5,
  parameter int CNT_W       = 16,
  parameter int DEF_DIV     = 10,
  parameter int DEF_HIGH    = 5,
  parameter int LOCK_CYCLES = 16
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               sync,
  soc_system_clk_div_if.slave cfg,
  output logic [NUM_CLK-1:0] outclk,
  output logic [NUM_CLK-1:0] outclk_en,
  output logic               locked
);
  localparam int CH_W = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t DEF_D = cnt_t'(DEF_DIV);
  localparam cnt_t DEF_H = cnt_t'(DEF_HIGH);
  localparam logic [15:0] LOCK_L = 16'(LOCK_CYCLES);
  localparam logic [CH_W:0] NUM_L = (CH_W+1)'(NUM_CLK);

  cnt_t div_q   [NUM_CLK];
  cnt_t high_q  [NUM_CLK];
  cnt_t cnt_q   [NUM_CLK];
  cnt_t pdiv_q  [NUM_CLK];
  cnt_t phigh_q [NUM_CLK];
  cnt_t div_n   [NUM_CLK];
  cnt_t high_n  [NUM_CLK];
  cnt_t cnt_n   [NUM_CLK];
`ifdef CLK_DIV_PHASE_EN
  cnt_t ph_q    [NUM_CLK];
  cnt_t pph_q   [NUM_CLK];
  cnt_t ph_n    [NUM_CLK];
`endif

  logic [NUM_CLK-1:0] pend_q;
  logic [NUM_CLK-1:0] wrap;
  logic [NUM_CLK-1:0] apply;
  logic [15:0]        lock_q;
  logic [15:0]        lock_n;
  logic               run_q;
  logic               chan_ok;
  logic               legal;
  logic               accept;
  logic               wr_ok;
  logic               restart;
  logic               clr;

  assign chan_ok = {1'b0, cfg.cfg_chan} < NUM_L;
  assign cfg.cfg_ready = chan_ok ? !pend_q[cfg.cfg_chan] : 1'b1;
  assign accept = cfg.cfg_valid & cfg.cfg_ready;

`ifdef CLK_DIV_PHASE_EN
  assign legal = (cfg.cfg_div >= cnt_t'(2))
    && (cfg.cfg_high != '0)
    && (cfg.cfg_high < cfg.cfg_div)
    && (cfg.cfg_phase < cfg.cfg_div);
`else
  assign legal = (cfg.cfg_div >= cnt_t'(2))
    && (cfg.cfg_high != '0)
    && (cfg.cfg_high < cfg.cfg_div);
`endif

  assign wr_ok = accept & legal & chan_ok;
  // First cycle out of reset behaves like a sync.
  assign restart = sync | !run_q;

  always_comb begin
    clr = sync;
    for (int i = 0; i < NUM_CLK; i++) begin
      wrap[i] = cnt_q[i] == div_q[i] - cnt_t'(1);
      apply[i] = pend_q[i] & (restart | wrap[i]);
      div_n[i] = apply[i] ? pdiv_q[i] : div_q[i];
      high_n[i] = apply[i] ? phigh_q[i] : high_q[i];
`ifdef CLK_DIV_PHASE_EN
      ph_n[i] = apply[i] ? pph_q[i] : ph_q[i];
      if (restart)
        cnt_n[i] = ph_n[i];
`else
      if (restart)
        cnt_n[i] = '0;
`endif
      else if (wrap[i])
        cnt_n[i] = '0;
      else
        cnt_n[i] = cnt_q[i] + cnt_t'(1);
      clr = clr | apply[i];
    end
    if (clr)
      lock_n = '0;
    else if (lock_q == LOCK_L)
      lock_n = lock_q;
    else
      lock_n = lock_q + 16'd1;
  end

  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLK; i++) begin
        div_q[i]   <= DEF_D;
        high_q[i]  <= DEF_H;
        cnt_q[i]   <= '0;
        pdiv_q[i]  <= DEF_D;
        phigh_q[i] <= DEF_H;
`ifdef CLK_DIV_PHASE_EN
        ph_q[i]    <= '0;
        pph_q[i]   <= '0;
`endif
      end
      pend_q      <= '0;
      run_q       <= 1'b0;
      outclk      <= '0;
      outclk_en   <= '0;
      cfg.cfg_err <= 1'b0;
      lock_q      <= '0;
      locked      <= 1'b0;
    end else begin
      run_q       <= 1'b1;
      cfg.cfg_err <= accept & ~(legal & chan_ok);
      lock_q      <= lock_n;
      locked      <= lock_n == LOCK_L;
      for (int i = 0; i < NUM_CLK; i++) begin
        div_q[i]     <= div_n[i];
        high_q[i]    <= high_n[i];
        cnt_q[i]     <= cnt_n[i];
`ifdef CLK_DIV_PHASE_EN
        ph_q[i]      <= ph_n[i];
`endif
        outclk[i]    <= cnt_n[i] < high_n[i];
        outclk_en[i] <= cnt_n[i] == '0;
        // A channel with pend set never accepts, so no store/apply clash.
        if (wr_ok && cfg.cfg_chan == CH_W'(i)) begin
          pdiv_q[i]  <= cfg.cfg_div;
          phigh_q[i] <= cfg.cfg_high;
`ifdef CLK_DIV_PHASE_EN
          pph_q[i]   <= cfg.cfg_phase;
`endif
          pend_q[i]  <= 1'b1;
        end else if (apply[i]) begin
          pend_q[i]  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_soc_system_clk_div.sv
// Bench for soc_system_clk_div: timeline model plus directed vectors.
// Phase vectors are added when CLK_DIV_PHASE_EN is defined.
module tb_soc_system_clk_div;
  localparam int NUM_CLK = 5;
  localparam int CNT_W   = 16;
  localparam int CH_W    = 3;
  localparam int LOCKC   = 16;

  logic               refclk = 1'b0;
  logic               rst_n;
  logic               sync;
  logic [NUM_CLK-1:0] outclk;
  logic [NUM_CLK-1:0] outclk_en;
  logic               locked;

  int checks = 0;
  int errors = 0;

  soc_system_clk_div_if #(.CH_W(CH_W), .CNT_W(CNT_W)) bus ();

  soc_system_clk_div #(
    .NUM_CLK(NUM_CLK), .CNT_W(CNT_W), .DEF_DIV(10),
    .DEF_HIGH(5), .LOCK_CYCLES(LOCKC)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .sync(sync), .cfg(bus),
    .outclk(outclk), .outclk_en(outclk_en), .locked(locked)
  );

  always #5 refclk = ~refclk;

  // Model: each channel is a periodic waveform anchored at cycle t0.
  int  m_div [NUM_CLK];
  int  m_high[NUM_CLK];
  int  m_ph  [NUM_CLK];
  int  p_div [NUM_CLK];
  int  p_high[NUM_CLK];
  int  p_ph  [NUM_CLK];
  bit  m_pend[NUM_CLK];
  int  t0    [NUM_CLK];
  int  tcur, tclr;
  bit  m_run, m_err, m_init;

  function automatic int pos(int i);
    int d;
    d = m_div[i];
    return (((tcur - t0[i]) % d) + d) % d;
  endfunction

  function automatic bit m_ready();
    if (int'(bus.cfg_chan) >= NUM_CLK) return 1'b1;
    return !m_pend[bus.cfg_chan];
  endfunction

  function automatic int in_ph();
`ifdef CLK_DIV_PHASE_EN
    return int'(bus.cfg_phase);
`else
    return 0;
`endif
  endfunction

  function automatic bit m_legal();
    int d, h;
    d = int'(bus.cfg_div);
    h = int'(bus.cfg_high);
    return d >= 2 && h >= 1 && h < d && in_ph() < d;
  endfunction

  always @(posedge refclk) begin
    bit acc, ok, ap;
    int c;
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLK; i++) begin
        m_div[i] = 10; m_high[i] = 5; m_ph[i] = 0;
        m_pend[i] = 0; t0[i] = 0;
      end
      tcur = 0; tclr = 0;
      m_run = 0; m_err = 0; m_init = 1;
    end else if (m_init) begin
      acc = bus.cfg_valid && m_ready();
      c = int'(bus.cfg_chan);
      ok = c < NUM_CLK && m_legal();
      for (int i = 0; i < NUM_CLK; i++) begin
        ap = m_pend[i] &&
          (!m_run || sync || pos(i) == m_div[i] - 1);
        if (ap) begin
          m_div[i] = p_div[i]; m_high[i] = p_high[i];
          m_ph[i] = p_ph[i]; m_pend[i] = 0;
          tclr = tcur + 1;
        end
        if (!m_run || sync) t0[i] = tcur + 1 - m_ph[i];
        else if (ap) t0[i] = tcur + 1;
      end
      if (sync) tclr = tcur + 1;
      m_err = acc && !ok;
      if (acc && ok) begin
        p_div[c] = int'(bus.cfg_div);
        p_high[c] = int'(bus.cfg_high);
        p_ph[c] = in_ph();
        m_pend[c] = 1;
      end
      tcur++;
      m_run = 1;
    end
  end

  task automatic cmp(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge refclk) begin
    logic [NUM_CLK-1:0] eo, ee;
    if (m_init) begin
      for (int i = 0; i < NUM_CLK; i++) begin
        eo[i] = m_run && pos(i) < m_high[i];
        ee[i] = m_run && pos(i) == 0;
      end
      cmp("outclk", 32'(outclk), 32'(eo));
      cmp("outclk_en", 32'(outclk_en), 32'(ee));
      cmp("locked", 32'(locked), 32'(m_run && tcur - tclr >= LOCKC));
      cmp("cfg_err", 32'(bus.cfg_err), 32'(m_err));
      cmp("cfg_ready", 32'(bus.cfg_ready), 32'(m_ready()));
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge refclk);
      #2;
    end
  endtask

  task automatic wr(int c, int d, int h
`ifdef CLK_DIV_PHASE_EN
    , int p = 0
`endif
  );
    bus.cfg_valid = 1'b1;
    bus.cfg_chan = CH_W'(c);
    bus.cfg_div = CNT_W'(d);
    bus.cfg_high = CNT_W'(h);
`ifdef CLK_DIV_PHASE_EN
    bus.cfg_phase = CNT_W'(p);
`endif
    tick(1);
    bus.cfg_valid = 1'b0;
  endtask

  int ic[4] = '{0, 0, 0, 7};
  int id[4] = '{1, 8, 8, 8};
  int ih[4] = '{1, 0, 8, 4};

  initial begin
    int n;
    bus.cfg_valid = 1'b0;
    bus.cfg_chan = '0;
    bus.cfg_div = '0;
    bus.cfg_high = '0;
`ifdef CLK_DIV_PHASE_EN
    bus.cfg_phase = '0;
`endif
    sync = 1'b0;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    cmp("rel_clk", 32'(outclk), 32'h1f);
    cmp("rel_en", 32'(outclk_en), 32'h1f);
    cmp("rel_lock", 32'(locked), 32'h0);
    tick(4);
    cmp("cnt4_clk", 32'(outclk), 32'h1f);
    cmp("cnt4_en", 32'(outclk_en), 32'h0);
    tick(1);
    cmp("cnt5_clk", 32'(outclk), 32'h0);
    tick(5);
    cmp("wrap_en", 32'(outclk_en), 32'h1f);
    tick(4);
    cmp("lock15", 32'(locked), 32'h0);
    tick(1);
    cmp("lock16", 32'(locked), 32'h1);

    // ch2 -> div 4 high 1, written mid-period
    bus.cfg_chan = 3'd2;
    cmp("rdy_free", 32'(bus.cfg_ready), 32'h1);
    wr(2, 4, 1);
    cmp("rdy_pend", 32'(bus.cfg_ready), 32'h0);
    tick(4);
    cmp("app_en", 32'(outclk_en), 32'h1f);
    cmp("app_lock", 32'(locked), 32'h0);
    tick(1);
    cmp("app_clk", 32'(outclk), 32'h1b);
    tick(3);
    cmp("ch2_en", 32'(outclk_en), 32'h04);
    cmp("ch2_clk", 32'(outclk), 32'h1f);

    for (int k = 0; k < 4; k++) begin
      wr(ic[k], id[k], ih[k]);
      cmp("err_pulse", 32'(bus.cfg_err), 32'h1);
      tick(1);
      cmp("err_clear", 32'(bus.cfg_err), 32'h0);
    end

    wr(2, 6, 3);
    bus.cfg_chan = 3'd2;
    cmp("rdy_busy", 32'(bus.cfg_ready), 32'h0);
    wr(3, 5, 2);
    bus.cfg_valid = 1'b1;
    bus.cfg_chan = 3'd2;
    bus.cfg_div = 16'd8;
    bus.cfg_high = 16'd2;
    n = 0;
    while (!bus.cfg_ready && n < 30) begin
      tick(1);
      n++;
    end
    cmp("rdy_wait", 32'(n < 30), 32'h1);
    tick(1);
    bus.cfg_valid = 1'b0;

    wr(4, 3, 1);
    n = 0;
    while (pos(0) != 6 && n < 20) begin
      tick(1);
      n++;
    end
    cmp("sync_wait", 32'(pos(0)), 32'd6);
    sync = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_chan = 3'd1;
    bus.cfg_div = 16'd4;
    bus.cfg_high = 16'd2;
    tick(1);
    sync = 1'b0;
    bus.cfg_valid = 1'b0;
    cmp("sync_en", 32'(outclk_en), 32'h1f);
    cmp("sync_clk", 32'(outclk), 32'h1f);
    cmp("sync_lock", 32'(locked), 32'h0);
    tick(40);

    wr(0, 3, 1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    cmp("rst_en", 32'(outclk_en), 32'h1f);
    cmp("rst_clk", 32'(outclk), 32'h1f);
    tick(5);
    cmp("rst_cnt5", 32'(outclk), 32'h0);
    tick(5);
    cmp("rst_wrap", 32'(outclk_en), 32'h1f);

`ifdef CLK_DIV_PHASE_EN
    wr(1, 10, 5, 3);
    tick(12);
    sync = 1'b1;
    tick(1);
    sync = 1'b0;
    cmp("ph_en0", 32'(outclk_en), 32'h1d);
    tick(7);
    cmp("ph_en7", 32'(outclk_en), 32'h02);
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    cmp("ph_rst", 32'(outclk_en), 32'h1f);
`endif

    tick(20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
